// File: rtl/pwm_counter.sv
// pwm_counter
//   Prescaled up/down timebase for the PWM block. The register file supplies
//   the programming fields, and this block returns the live count. Each
//   counter step raises a one-cycle tick. Each period boundary raises a
//   one-cycle wrap, which the PWM output stage consumes.
//
// Ports
//   clk          system clock, all state changes on posedge
//   rst          synchronous active-high reset, highest priority
//   en           counter enable; 0 freezes counter and prescaler
//   count_reset  one-cycle clear of counter and prescaler
//   upnotdown    1 = count up, 0 = count down
//   period       terminal count (inclusive), CNT_W bits
//   prescale     one step every prescale+1 enabled clocks, PSC_W bits
//   counter_val  current count (registered)
//   wrap         one-cycle pulse on period wrap (registered)
//   tick         one-cycle pulse on every counter step (registered)
module pwm_counter #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] counter_val,
    output logic             wrap,
    output logic             tick
);

    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [PSC_W-1:0] psc_cnt_reg, psc_cnt_next;
    logic             wrap_reg, wrap_next;
    logic             tick_reg, tick_next;
    logic             en_d_reg, en_d_next;

    always_comb begin
        counter_next = counter_reg;
        psc_cnt_next = psc_cnt_reg;
        wrap_next    = 1'b0;
        tick_next    = 1'b0;
        en_d_next    = en;

        if (count_reset) begin
            counter_next = '0;
            psc_cnt_next = '0;
        end else if (!en) begin
            // Frozen: counter and prescaler hold and the pulses stay low.
        end else if (!en_d_reg) begin
            // Enable just rose. Restart the prescaler so that the first step
            // lands prescale+1 clocks from now.
            psc_cnt_next = '0;
        end else if (psc_cnt_reg >= prescale) begin
            // Using >= means that lowering prescale mid-count still steps on
            // the next enabled clock. Without it the count would have to run
            // the full prescaler range before matching again.
            psc_cnt_next = '0;
            tick_next    = 1'b1;
            if (upnotdown) begin
                // Using >= also covers a period written below the current count.
                if (counter_reg >= period) begin
                    counter_next = '0;
                    wrap_next    = 1'b1;
                end else begin
                    counter_next = counter_reg + 1'b1;
                end
            end else begin
                if (counter_reg == '0) begin
                    counter_next = period;
                    wrap_next    = 1'b1;
                end else if (counter_reg > period) begin
                    // Resync after period was lowered. This is not a wrap.
                    counter_next = period;
                end else begin
                    counter_next = counter_reg - 1'b1;
                end
            end
        end else begin
            psc_cnt_next = psc_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg <= '0;
            psc_cnt_reg <= '0;
            wrap_reg    <= 1'b0;
            tick_reg    <= 1'b0;
            en_d_reg    <= 1'b0;
        end else begin
            counter_reg <= counter_next;
            psc_cnt_reg <= psc_cnt_next;
            wrap_reg    <= wrap_next;
            tick_reg    <= tick_next;
            en_d_reg    <= en_d_next;
        end
    end

    assign counter_val = counter_reg;
    assign wrap        = wrap_reg;
    assign tick        = tick_reg;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed testbench for pwm_counter. Expected values are hand-derived
// from the counter's behaviour and are checked after every clock edge.
module tb_pwm_counter;

    localparam int CNT_W = 16;
    localparam int PSC_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             count_reset;
    logic             upnotdown;
    logic [CNT_W-1:0] period;
    logic [PSC_W-1:0] prescale;
    logic [CNT_W-1:0] counter_val;
    logic             wrap;
    logic             tick;

    int vectors = 0;
    int errors  = 0;

    pwm_counter #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .counter_val (counter_val),
        .wrap        (wrap),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns after the edge, away from it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse count_reset for one clock while leaving en unchanged.
    task automatic pulse_clear();
        count_reset = 1'b1;
        cycle();
        count_reset = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'd3; prescale = 8'd0;
        cycle();
        cycle();
        vectors++;
        if (counter_val !== 16'd0 || wrap !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset: counter_val=%0h wrap=%b tick=%b, expected 0 0 0", counter_val, wrap, tick);
        end else
            $display("reset: counter_val=0 wrap=0 tick=0");
        rst = 1'b0;
    endtask

    task automatic test_up_basic();
        logic [CNT_W-1:0] exp_cnt;
        upnotdown = 1'b1; period = 16'd3; prescale = 8'd0; en = 1'b0;
        pulse_clear();
        en = 1'b1;
        cycle(); // rising-edge cycle: no step
        vectors++;
        if (counter_val !== 16'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL up_basic_rise: counter_val=%0d tick=%b wrap=%b, expected 0 0 0", counter_val, tick, wrap);
        end
        for (int i = 1; i <= 8; i++) begin
            cycle();
            exp_cnt = CNT_W'(i % 4);
            vectors++;
            if (counter_val !== exp_cnt || tick !== 1'b1 || wrap !== (exp_cnt == 0)) begin
                errors++;
                $display("FAIL up_basic[%0d]: counter_val=%0d tick=%b wrap=%b, expected %0d 1 %b",
                         i, counter_val, tick, wrap, exp_cnt, exp_cnt == 0);
            end else
                $display("up_basic[%0d]: counter_val=%0d wrap=%b", i, counter_val, wrap);
        end
    endtask

    task automatic test_prescale();
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_tick;
        upnotdown = 1'b1; period = 16'd5; prescale = 8'd3; en = 1'b0;
        pulse_clear();
        en = 1'b1;
        cycle(); // rising-edge cycle
        for (int k = 1; k <= 28; k++) begin
            cycle();
            exp_tick = (k % 4 == 0);
            exp_cnt  = CNT_W'((k / 4) % 6);
            vectors++;
            if (counter_val !== exp_cnt || tick !== exp_tick || wrap !== (exp_tick && exp_cnt == 0)) begin
                errors++;
                $display("FAIL prescale[%0d]: counter_val=%0d tick=%b wrap=%b, expected %0d %b %b",
                         k, counter_val, tick, wrap, exp_cnt, exp_tick, exp_tick && exp_cnt == 0);
            end else
                $display("prescale[%0d]: counter_val=%0d tick=%b wrap=%b", k, counter_val, tick, wrap);
        end
    endtask

    task automatic test_down();
        logic [CNT_W-1:0] exp_seq [6];
        exp_seq = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd4};
        upnotdown = 1'b0; period = 16'd4; prescale = 8'd0; en = 1'b1;
        pulse_clear(); // en held high: clear wins, no rise afterwards
        vectors++;
        if (counter_val !== 16'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL down_clear: counter_val=%0d tick=%b, expected 0 0", counter_val, tick);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            vectors++;
            if (counter_val !== exp_seq[i] || wrap !== (exp_seq[i] == 16'd4)) begin
                errors++;
                $display("FAIL down[%0d]: counter_val=%0d wrap=%b, expected %0d %b",
                         i, counter_val, wrap, exp_seq[i], exp_seq[i] == 16'd4);
            end else
                $display("down[%0d]: counter_val=%0d wrap=%b", i, counter_val, wrap);
        end
    endtask

    task automatic test_period_lower();
        // Up case: reach 10, lower period to 6, expect wrap to 0.
        upnotdown = 1'b1; period = 16'd100; prescale = 8'd0; en = 1'b1;
        pulse_clear();
        repeat (10) cycle();
        vectors++;
        if (counter_val !== 16'd10) begin
            errors++;
            $display("FAIL lower_up_pre: counter_val=%0d, expected 10", counter_val);
        end
        period = 16'd6;
        cycle();
        vectors++;
        if (counter_val !== 16'd0 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL lower_up: counter_val=%0d wrap=%b, expected 0 1", counter_val, wrap);
        end else
            $display("lower_up: counter_val=0 wrap=1");
        // Down case: reach 10, lower period to 6, expect resync to 6 without a wrap.
        period = 16'd100;
        pulse_clear();
        repeat (10) cycle();
        upnotdown = 1'b0; period = 16'd6;
        cycle();
        vectors++;
        if (counter_val !== 16'd6 || wrap !== 1'b0 || tick !== 1'b1) begin
            errors++;
            $display("FAIL lower_down: counter_val=%0d wrap=%b tick=%b, expected 6 0 1", counter_val, wrap, tick);
        end else
            $display("lower_down: counter_val=6 wrap=0");
    endtask

    task automatic test_en_hold();
        upnotdown = 1'b1; period = 16'd100; prescale = 8'd2; en = 1'b1;
        pulse_clear();
        repeat (21) cycle(); // 7 steps at 3 clocks each
        vectors++;
        if (counter_val !== 16'd7 || tick !== 1'b1) begin
            errors++;
            $display("FAIL en_hold_pre: counter_val=%0d tick=%b, expected 7 1", counter_val, tick);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors++;
            if (counter_val !== 16'd7 || tick !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL en_hold[%0d]: counter_val=%0d tick=%b wrap=%b, expected 7 0 0", i, counter_val, tick, wrap);
            end
        end
        en = 1'b1;
        cycle(); // rise
        cycle();
        cycle();
        vectors++;
        if (counter_val !== 16'd7 || tick !== 1'b0) begin
            errors++;
            $display("FAIL en_rerise_early: counter_val=%0d tick=%b, expected 7 0", counter_val, tick);
        end
        cycle(); // prescale+1 = 3 clocks after the rise
        vectors++;
        if (counter_val !== 16'd8 || tick !== 1'b1) begin
            errors++;
            $display("FAIL en_rerise: counter_val=%0d tick=%b, expected 8 1", counter_val, tick);
        end else
            $display("en_rerise: counter_val=8 tick=1");
    endtask

    task automatic test_clear_and_reset();
        upnotdown = 1'b1; period = 16'hFFFF; prescale = 8'd0; en = 1'b1;
        pulse_clear();
        repeat (16'h1234) cycle();
        vectors++;
        if (counter_val !== 16'h1234) begin
            errors++;
            $display("FAIL clear_pre: counter_val=%0h, expected 1234", counter_val);
        end
        pulse_clear();
        vectors++;
        if (counter_val !== 16'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid: counter_val=%0h tick=%b wrap=%b, expected 0 0 0", counter_val, tick, wrap);
        end else
            $display("clear_mid: counter_val=0");
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++;
        if (counter_val !== 16'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: counter_val=%0h tick=%b wrap=%b, expected 0 0 0", counter_val, tick, wrap);
        end else
            $display("rst_mid: counter_val=0 tick=0 wrap=0");
    endtask

    task automatic test_period_zero();
        upnotdown = 1'b1; period = 16'd0; prescale = 8'd0; en = 1'b1;
        cycle(); // en_d was cleared by reset, so this is a rising-edge cycle
        vectors++;
        if (tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL pzero_rise: tick=%b wrap=%b, expected 0 0", tick, wrap);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (counter_val !== 16'd0 || tick !== 1'b1 || wrap !== 1'b1) begin
                errors++;
                $display("FAIL pzero[%0d]: counter_val=%0d tick=%b wrap=%b, expected 0 1 1", i, counter_val, tick, wrap);
            end else
                $display("pzero[%0d]: counter_val=0 wrap=1", i);
        end
        upnotdown = 1'b0; // down with period 0 also reloads 0 and wraps
        cycle();
        vectors++;
        if (counter_val !== 16'd0 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL pzero_down: counter_val=%0d wrap=%b, expected 0 1", counter_val, wrap);
        end
    endtask

    initial begin
        test_reset();
        test_up_basic();
        test_prescale();
        test_down();
        test_period_lower();
        test_en_hold();
        test_clear_and_reset();
        test_period_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
